conf_regs: RTL and testbench



---
 rtl/conf_regs.sv | 110 +++++++++++
 tb/tb_conf_regs.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/conf_regs.sv
// conf_regs: card configuration register bank (COR, CCSR, SCR) for the attribute-memory window.
// Ports:
//   CLK, RESETB           clock, synchronous active-low reset
//   A, D_in, REGSELB, WE  host write address/data, attribute select, write strobe (active-low)
//   OE, DDIR, D_out       host read strobe (active-low), buffer direction, read data
//   IRQ_IN, IREQB         function interrupt in (async), interrupt to host (active-low)
//   CONFIGURED, SOFT_RESET, PWRDWN  function enable, function-core reset, power-down request
module conf_regs #(
    parameter int ADDR_W        = 16,
    parameter int SEL_BIT       = 9,
    parameter int CONFIG_INDEX  = 1,
    parameter int SRESET_CYCLES = 16,
    parameter int PULSE_CYCLES  = 8
) (
    input  logic              CLK,
    input  logic              RESETB,
    input  logic [7:0]        D_in,
    output logic [7:0]        D_out,
    input  logic [ADDR_W-1:0] A,
    output logic              DDIR,
    input  logic              REGSELB,
    input  logic              OE,
    input  logic              WE,
    input  logic              IRQ_IN,
    output logic              IREQB,
    output logic              CONFIGURED,
    output logic              SOFT_RESET,
    output logic              PWRDWN
);
    localparam int SW = $clog2(SRESET_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    logic          we_m, we_s, we_d, irq_m, irq_s, irq_d;
    logic [8:0]    a_c;
    logic [7:0]    d_c, cor, scr;
    logic          sel_c, intr, pwr, aud, cfg, ireq;
    logic [SW-1:0] scnt;
    logic [PW-1:0] pcnt, pcnt_n;
    logic          commit, w_cor, w_ccsr, w_scr, rise, lev, clr;
    logic          unused_a;

    assign unused_a   = ^A;
    assign commit     = we_s & ~we_d & sel_c;
    assign w_cor      = commit & (a_c == 9'h000);
    assign w_ccsr     = commit & (a_c == 9'h002);
    assign w_scr      = commit & (a_c == 9'h004);
    assign rise       = irq_s & ~irq_d;
    assign lev        = cor[6];
    assign clr        = w_ccsr & d_c[1];
    assign SOFT_RESET = cor[7] | (scnt != '0);
    assign DDIR       = ~REGSELB & ~OE & A[SEL_BIT];
    assign CONFIGURED = cfg;
    assign IREQB      = ireq;
    assign PWRDWN     = pwr;

    always_comb begin
        D_out  = (A[8:0] == 9'h000) ? cor :
                 (A[8:0] == 9'h002) ? {4'b0, aud, pwr, intr, 1'b0} :
                 (A[8:0] == 9'h004) ? scr : 8'h00;
        // pulse counter only runs in configured pulse mode; an edge reloads it
        pcnt_n = (!cfg || lev) ? '0 :
                 rise          ? PW'(PULSE_CYCLES) :
                 (pcnt != '0)  ? pcnt - 1'b1 : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            // WE synchroniser rests at the idle (high) level so no capture follows reset
            {we_d, we_s, we_m}    <= 3'b111;
            {irq_d, irq_s, irq_m} <= 3'b000;
            a_c   <= '0;
            d_c   <= '0;
            sel_c <= 1'b0;
            cor   <= '0;
            scr   <= '0;
            intr  <= 1'b0;
            pwr   <= 1'b0;
            aud   <= 1'b0;
            cfg   <= 1'b0;
            ireq  <= 1'b1;
            scnt  <= '0;
            pcnt  <= '0;
        end else begin
            {we_d, we_s, we_m}    <= {we_s, we_m, WE};
            {irq_d, irq_s, irq_m} <= {irq_s, irq_m, IRQ_IN};
            if (!we_s) begin
                a_c   <= A[8:0];
                d_c   <= D_in;
                sel_c <= ~REGSELB & A[SEL_BIT];
            end
            scnt <= (scnt != '0) ? scnt - 1'b1 : scnt;
            cfg  <= (cor[5:0] == 6'(CONFIG_INDEX)) & ~SOFT_RESET;
            // set wins over a simultaneous host clear
            intr <= !cfg ? 1'b0 : lev ? irq_s : (rise | (intr & ~clr));
            pcnt <= pcnt_n;
            ireq <= ~(cfg & (lev ? irq_s : (pcnt_n != '0)));
            if (w_scr)
                scr <= d_c;
            if (w_ccsr)
                {aud, pwr} <= d_c[3:2];
            if (w_cor) begin
                cor <= d_c[7] ? 8'h80 : d_c;
                if (d_c[7]) begin
                    {aud, pwr, intr} <= 3'b000;
                    scnt <= SW'(SRESET_CYCLES);
                end
            end
        end
    end
endmodule

// File: tb/tb_conf_regs.sv
// tb_conf_regs: directed, table-driven self-checking bench for conf_regs.
module tb_conf_regs;
    logic        CLK = 1'b0, RESETB, REGSELB, OE, WE, IRQ_IN;
    logic [7:0]  D_in, D_out;
    logic [15:0] A;
    logic        DDIR, IREQB, CONFIGURED, SOFT_RESET, PWRDWN;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [15:0] wa;
        logic [7:0]  wd;
        logic        rsb;
        logic [15:0] ra;
        logic [7:0]  exp;
    } vec_t;
    vec_t tv[8];

    conf_regs dut (
        .CLK(CLK), .RESETB(RESETB), .D_in(D_in), .D_out(D_out), .A(A), .DDIR(DDIR),
        .REGSELB(REGSELB), .OE(OE), .WE(WE), .IRQ_IN(IRQ_IN), .IREQB(IREQB),
        .CONFIGURED(CONFIGURED), .SOFT_RESET(SOFT_RESET), .PWRDWN(PWRDWN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [15:0] a, input logic [7:0] exp);
        A = a;
        REGSELB = 1'b0;
        OE = 1'b0;
        #1;
        chk({nm, "_ddir"}, DDIR, 1);
        chk(nm, D_out, exp);
        OE = 1'b1;
        REGSELB = 1'b1;
        #1;
    endtask

    // returns 1 ns after the commit edge (third edge after WE rises)
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic rsb);
        A = a;
        D_in = d;
        REGSELB = rsb;
        WE = 1'b0;
        repeat (3) tick();
        WE = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        tv[0] = '{16'h0204, 8'hA5, 1'b0, 16'h0204, 8'hA5};
        tv[1] = '{16'h0202, 8'h0C, 1'b0, 16'h0202, 8'h0C};
        tv[2] = '{16'h0206, 8'hFF, 1'b0, 16'h0206, 8'h00};
        tv[3] = '{16'h0004, 8'h11, 1'b0, 16'h0204, 8'hA5};
        tv[4] = '{16'h0204, 8'h22, 1'b1, 16'h0204, 8'hA5};
        tv[5] = '{16'h0206, 8'hFF, 1'b0, 16'h0204, 8'hA5};
        tv[6] = '{16'h0202, 8'hF0, 1'b1, 16'h0202, 8'h0C};
        tv[7] = '{16'h0200, 8'h00, 1'b1, 16'h0200, 8'h01};

        RESETB = 1'b0; REGSELB = 1'b1; OE = 1'b1; WE = 1'b1; IRQ_IN = 1'b0;
        A = '0; D_in = '0;
        repeat (3) tick();
        chk("rst_ireqb", IREQB, 1);
        chk("rst_cfg", CONFIGURED, 0);
        chk("rst_sreset", SOFT_RESET, 0);
        chk("rst_pwrdwn", PWRDWN, 0);
        rd("rst_cor", 16'h0200, 8'h00);
        RESETB = 1'b1;
        tick();
        A = 16'h0000; REGSELB = 1'b0; OE = 1'b0; #1;
        chk("ddir_a9_low", DDIR, 0);
        OE = 1'b1; REGSELB = 1'b1; #1;

        wr(16'h0200, 8'h01, 1'b0);
        chk("cfg_wait3", CONFIGURED, 0);
        tick();
        chk("cfg_wait4", CONFIGURED, 1);
        rd("cor_01", 16'h0200, 8'h01);

        wr(16'h0200, 8'h81, 1'b0);
        chk("sr_set", SOFT_RESET, 1);
        rd("cor_80", 16'h0200, 8'h80);
        tick();
        chk("sr_cfg_low", CONFIGURED, 0);
        repeat (2) tick();
        wr(16'h0200, 8'h01, 1'b0);
        chk("sr_hold9", SOFT_RESET, 1);
        rd("cor_back01", 16'h0200, 8'h01);
        repeat (6) tick();
        chk("sr_hold15", SOFT_RESET, 1);
        tick();
        chk("sr_end16", SOFT_RESET, 0);
        chk("sr_cfg16", CONFIGURED, 0);
        tick();
        chk("sr_cfg17", CONFIGURED, 1);

        wr(16'h0200, 8'h41, 1'b0);
        IRQ_IN = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk($sformatf("lev_ireqb_%0d", k), IREQB, (k >= 3 && k <= 22) ? 0 : 1);
            if (k == 10) rd("lev_ccsr_hi", 16'h0202, 8'h02);
            if (k == 20) IRQ_IN = 1'b0;
        end
        rd("lev_ccsr_lo", 16'h0202, 8'h00);

        wr(16'h0200, 8'h01, 1'b0);
        IRQ_IN = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk($sformatf("pul_ireqb_%0d", k), IREQB, (k >= 3 && k <= 10) ? 0 : 1);
        end
        rd("pul_sticky", 16'h0202, 8'h02);
        wr(16'h0202, 8'h02, 1'b0);
        rd("pul_clear", 16'h0202, 8'h00);

        IRQ_IN = 1'b0;
        repeat (3) tick();
        A = 16'h0202; D_in = 8'h02; REGSELB = 1'b0; WE = 1'b0;
        repeat (3) tick();
        WE = 1'b1; IRQ_IN = 1'b1;
        repeat (3) tick();
        chk("setclr_ireqb", IREQB, 0);
        rd("setclr_intr", 16'h0202, 8'h02);

        wr(16'h0200, 8'h41, 1'b0);
        repeat (2) tick();
        chk("mode_lev_ireqb", IREQB, 0);
        wr(16'h0200, 8'h01, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("mode_nopulse_%0d", k), IREQB, 1);
        end
        IRQ_IN = 1'b0;
        repeat (3) tick();
        wr(16'h0202, 8'h02, 1'b0);
        rd("mode_clear", 16'h0202, 8'h00);

        for (int i = 0; i < 8; i++) begin
            wr(tv[i].wa, tv[i].wd, tv[i].rsb);
            rd($sformatf("tv%0d", i), tv[i].ra, tv[i].exp);
        end
        chk("pwrdwn_set", PWRDWN, 1);

        IRQ_IN = 1'b1;
        repeat (5) tick();
        chk("midpulse_ireqb", IREQB, 0);
        RESETB = 1'b0;
        tick();
        chk("rp_ireqb", IREQB, 1);
        chk("rp_cfg", CONFIGURED, 0);
        chk("rp_pwrdwn", PWRDWN, 0);
        chk("rp_sreset", SOFT_RESET, 0);
        rd("rp_cor", 16'h0200, 8'h00);
        rd("rp_ccsr", 16'h0202, 8'h00);
        rd("rp_scr", 16'h0204, 8'h00);
        RESETB = 1'b1; IRQ_IN = 1'b0;
        repeat (3) tick();

        A = 16'h0204; D_in = 8'h77; REGSELB = 1'b0; WE = 1'b0;
        repeat (3) tick();
        RESETB = 1'b0;
        repeat (2) tick();
        WE = 1'b1;
        repeat (2) tick();
        RESETB = 1'b1;
        repeat (5) tick();
        rd("rw_scr", 16'h0204, 8'h00);
        chk("rw_ireqb", IREQB, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
